result_buffer: RTL and testbench

RESULT_BUFFER -- requirements
Module: result_buffer

---
 rtl/cnn_buf_pkg.sv | 13 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/result_buffer.sv | 143 ++++++++++++++
 tb/tb_result_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_buf_pkg.sv
// Shared definitions for the CNN result-path buffers: bus width, default
// element width and the two-state pack machine encoding.
package cnn_buf_pkg;

    localparam int AXI_WIDTH      = 32;
    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        LO_EMPTY   = 1'b0,
        HI_PENDING = 1'b1
    } pack_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; occupancy is tracked by an explicit counter so
// full/empty never rely on pointer equality.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array, cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == {CW{1'b0}});
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

endmodule

// File: rtl/result_buffer.sv
// Packs systolic-array result elements two per 32-bit word into a FIFO.
// Optional RESULT_BUFFER_ROW_PAD_EN flushes a half word at the end of odd rows.
module result_buffer
    import cnn_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_vld,
    input  logic [DATA_WIDTH-1:0]  data_in,
    output logic                   in_rdy,
    input  logic [4:0]             result_dim,
    output logic [AXI_WIDTH-1:0]   out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] level
);

    localparam int HALF = AXI_WIDTH / 2;

    pack_state_t          r_state;
    pack_state_t          w_state_nxt;
    logic [HALF-1:0]      r_lo;
    logic [HALF-1:0]      w_lo_nxt;
    logic [HALF-1:0]      w_elem;
    logic [4:0]           r_row_cnt;
    logic                 r_done;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_row_last;
    logic                 w_push;
    logic [AXI_WIDTH-1:0] w_push_data;

    if (DATA_WIDTH >= HALF) begin : g_trunc
        assign w_elem = data_in[HALF-1:0];
    end else begin : g_ext
        assign w_elem = {{(HALF-DATA_WIDTH){1'b0}}, data_in};
    end

    assign in_rdy     = !w_full;
    assign w_accept   = in_vld && in_rdy;
    assign w_row_last = w_accept && (result_dim != 5'd0) &&
                        (r_row_cnt == (result_dim - 5'd1));

    // Pack machine: low half first, the high half completes and pushes the word
    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_push      = 1'b0;
        w_push_data = {AXI_WIDTH{1'b0}};
        case (r_state)
            LO_EMPTY: begin
                if (w_accept) begin
`ifdef RESULT_BUFFER_ROW_PAD_EN
                    if (w_row_last && result_dim[0]) begin
                        w_push      = 1'b1;
                        w_push_data = {{HALF{1'b0}}, w_elem};
                        w_lo_nxt    = {HALF{1'b0}};
                    end else begin
                        w_lo_nxt    = w_elem;
                        w_state_nxt = HI_PENDING;
                    end
`else
                    w_lo_nxt    = w_elem;
                    w_state_nxt = HI_PENDING;
`endif
                end else begin
                    w_state_nxt = LO_EMPTY;
                end
            end
            HI_PENDING: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_data = {w_elem, r_lo};
                    w_lo_nxt    = {HALF{1'b0}};
                    w_state_nxt = LO_EMPTY;
                end else begin
                    w_state_nxt = HI_PENDING;
                end
            end
            default: begin
                w_state_nxt = LO_EMPTY;
                w_lo_nxt    = {HALF{1'b0}};
            end
        endcase
    end

    // Pack state and pending low half
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= LO_EMPTY;
            r_lo    <= {HALF{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Row counter idles at zero while row tracking is disabled
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_row_cnt <= 5'd0;
        end else if (result_dim == 5'd0) begin
            r_row_cnt <= 5'd0;
        end else if (w_row_last) begin
            r_row_cnt <= 5'd0;
        end else if (w_accept) begin
            r_row_cnt <= r_row_cnt + 5'd1;
        end
    end

    // End-of-row pulse, one cycle after the last element of the row
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_row_last;
        end
    end

    assign done    = r_done;
    assign out_vld = !w_empty;

    sync_fifo #(
        .WIDTH (AXI_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (w_push),
        .wdata (w_push_data),
        .pop   (out_vld && out_rdy),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty),
        .count (level)
    );

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed scenarios plus random traffic
// checked against a queue-based packing model.
module tb_result_buffer;

    localparam int DEPTH = 8;

    logic        clk;
    logic        nrst;
    logic        in_vld;
    logic [15:0] data_in;
    logic        in_rdy;
    logic [4:0]  result_dim;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_rdy;
    logic        done;
    logic [3:0]  level;

    int          total;
    int          bad;
    int          words_popped;
    int          done_cnt;
    int          row_idx;
    logic        exp_done;
    logic [31:0] exp_q [$];
    logic [15:0] pend  [$];

    result_buffer #(.DATA_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_vld     (in_vld),
        .data_in    (data_in),
        .in_rdy     (in_rdy),
        .result_dim (result_dim),
        .out_data   (out_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .done       (done),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference packing: two elements per word, low half first, rows counted by result_dim.
    function automatic void model_accept(input logic [15:0] d);
        logic last;
        last = 1'b0;
        pend.push_back(d);
        if (result_dim != 5'd0) begin
            row_idx++;
            if (row_idx == int'(result_dim)) begin
                row_idx = 0;
                last    = 1'b1;
            end
        end
        if (pend.size() == 2) begin
            exp_q.push_back({pend[1], pend[0]});
            pend.delete();
        end
`ifdef RESULT_BUFFER_ROW_PAD_EN
        else if (last && (int'(result_dim) % 2 == 1)) begin
            exp_q.push_back({16'h0000, pend[0]});
            pend.delete();
        end
`endif
        exp_done = last;
    endfunction

    task automatic tick();
        logic        acc;
        logic        pop;
        logic [31:0] popped;
        acc    = in_vld && (exp_q.size() < DEPTH);
        pop    = out_rdy && (exp_q.size() > 0);
        popped = out_data;
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (pop) begin
            chk("pop_word", popped, exp_q[0]);
            void'(exp_q.pop_front());
            words_popped++;
        end
        if (acc) model_accept(data_in);
        if (done) done_cnt++;
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("out_vld", 32'(out_vld), 32'(exp_q.size() > 0));
        chk("in_rdy", 32'(in_rdy), 32'(exp_q.size() < DEPTH));
        chk("done", 32'(done), 32'(exp_done));
        if (exp_q.size() > 0) chk("head", out_data, exp_q[0]);
    endtask

    task automatic send(input logic v, input logic [15:0] d, input logic r);
        in_vld  = v;
        data_in = d;
        out_rdy = r;
        tick();
    endtask

    task automatic do_reset();
        in_vld = 1'b0;
        nrst   = 1'b0;
        #2;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        exp_q.delete();
        pend.delete();
        row_idx  = 0;
        exp_done = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) send(1'b0, 16'h0, 1'b1);
        chk("drained", 32'(level), 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; words_popped = 0; done_cnt = 0;
        row_idx = 0; exp_done = 1'b0;
        nrst = 1'b0; in_vld = 1'b0; data_in = 16'h0; out_rdy = 1'b0; result_dim = 5'd0;
        #3;
        do_reset();

        // basic packing 1,2,3,4
        send(1'b1, 16'd1, 1'b1);
        chk("lat_before", 32'(out_vld), 32'd0);
        send(1'b1, 16'd2, 1'b1);
        chk("word0", out_data, 32'h0002_0001);
        send(1'b1, 16'd3, 1'b1);
        send(1'b1, 16'd4, 1'b1);
        chk("word1", out_data, 32'h0004_0003);
        drain();

        // row handling, result_dim = 3
        result_dim = 5'd3;
        do_reset();
        done_cnt = 0;
        send(1'b1, 16'd1, 1'b0);
        send(1'b1, 16'd2, 1'b0);
        send(1'b1, 16'd3, 1'b0);
        chk("row_done_pulse", 32'(done), 32'd1);
        send(1'b0, 16'd0, 1'b0);
        chk("row_done_cnt", 32'(done_cnt), 32'd1);
`ifdef RESULT_BUFFER_ROW_PAD_EN
        chk("pad_level", 32'(level), 32'd2);
`else
        chk("nopad_level", 32'(level), 32'd1);
`endif
        send(1'b1, 16'd4, 1'b0);
        drain();

        // full behaviour
        result_dim = 5'd0;
        do_reset();
        for (int i = 0; i < 20; i++) send(1'b1, 16'(i + 1), 1'b0);
        chk("full_level", 32'(level), 32'd8);
        chk("full_in_rdy", 32'(in_rdy), 32'd0);
        drain();
        chk("full_rdy_back", 32'(in_rdy), 32'd1);

        // simultaneous push and pop at level 4
        do_reset();
        for (int i = 0; i < 9; i++) send(1'b1, 16'(16'h10 + i), 1'b0);
        send(1'b1, 16'h0019, 1'b1);
        chk("simul_level", 32'(level), 32'd4);
        drain();

        // reset mid-operation
        for (int i = 0; i < 7; i++) send(1'b1, 16'(16'h30 + i), 1'b0);
        do_reset();
        send(1'b1, 16'h000A, 1'b0);
        send(1'b1, 16'h000B, 1'b0);
        chk("rst_word", out_data, 32'h000B_000A);
        drain();

        // wrap-around with out_rdy toggling
        words_popped = 0;
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 400 && sent < 40; c++) begin
                if (exp_q.size() < DEPTH) sent++;
                send(1'b1, 16'($urandom), c[0]);
            end
            chk("wrap_sent", 32'(sent), 32'd40);
        end
        drain();
        chk("wrap_words", 32'(words_popped), 32'd20);

        // random traffic with random row lengths
        for (int r = 0; r < 5; r++) begin
            result_dim = 5'($urandom_range(0, 7));
            do_reset();
            for (int c = 0; c < 80; c++)
                send($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom_range(0, 1)));
            in_vld = 1'b0;
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
